// File: rtl/sfd_pkg.sv
// Shared definitions for the serial frame deserializer: FSM states,
// line-level framing constants and a frame-length helper.
package sfd_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } sfd_state_e;

    // Line idles low, so a frame is opened by a 1 and closed by a 0
    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Total bit times per frame: start + payload + optional parity + stop
    function automatic int unsigned sfd_frame_len(input int unsigned data_w,
                                                  input int unsigned parity_en);
        return data_w + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/sfd_shift_core.sv
// Direction-selectable payload shift register with bit counter and
// running even parity. dir=0 shifts right (first bit lands in [0]),
// dir=1 shifts left (first bit lands in [DATA_W-1]).
module sfd_shift_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic              dir,
    input  logic              din,
    output logic [DATA_W-1:0] word,
    output logic              par,
    output logic              last
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [CW-1:0] cnt;

    // High while the bit being shifted in is the final payload bit
    assign last = (cnt == CW'(DATA_W - 1));

    // Shift register, bit counter and running parity; clr restarts a frame
    // without touching the word so a finished word stays readable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            cnt  <= '0;
            par  <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            par  <= 1'b0;
        end else if (shift) begin
            word <= dir ? {word[DATA_W-2:0], din} : {din, word[DATA_W-1:1]};
            cnt  <= cnt + CW'(1);
            par  <= par ^ din;
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Frames a 1-bit stream (start=1, payload, optional even parity, stop=0)
// and presents each assembled word on a valid/ready handshake.
// The stop bit is judged one edge before the output register updates,
// so the next frame's start bit can be sampled on that same edge.
module serial_frame_deserializer
    import sfd_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              mode,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    sfd_state_e        st, st_n;

    logic              core_clr;
    logic              core_shift;
    logic [DATA_W-1:0] core_word;
    logic              core_par;
    logic              core_last;

    logic              mode_q;
    logic              perr_q;
    logic              par_chk;
    logic              fin_ok, fin_ok_n;
    logic              fin_err, fin_err_n;
    logic              xfer;

    assign xfer = valid & ready;
    assign busy = (st != ST_IDLE);

    sfd_shift_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (core_clr),
        .shift (core_shift),
        .dir   (mode_q),
        .din   (in),
        .word  (core_word),
        .par   (core_par),
        .last  (core_last)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= ST_IDLE;
        else      st <= st_n;
    end

    // Next-state decode plus per-state strobes to the core and frame flags
    always_comb begin
        st_n       = st;
        core_clr   = 1'b0;
        core_shift = 1'b0;
        par_chk    = 1'b0;
        fin_ok_n   = 1'b0;
        fin_err_n  = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (in == START_BIT) begin
                    core_clr = 1'b1;
                    st_n     = ST_DATA;
                end
            end
            ST_DATA: begin
                core_shift = 1'b1;
                if (core_last) st_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                par_chk = 1'b1;
                st_n    = ST_STOP;
            end
            ST_STOP: begin
                st_n = ST_IDLE;
                if (in == STOP_BIT) fin_ok_n  = 1'b1;
                else                fin_err_n = 1'b1;
            end
            default: st_n = ST_IDLE;
        endcase
    end

    // Per-frame context: bit order latched with the start bit, parity verdict,
    // and the one-cycle delivery/discard flags produced by the stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= 1'b0;
            perr_q  <= 1'b0;
            fin_ok  <= 1'b0;
            fin_err <= 1'b0;
        end else begin
            fin_ok  <= fin_ok_n;
            fin_err <= fin_err_n;
            if (core_clr) mode_q <= mode;
            if (par_chk)  perr_q <= (in != core_par);
        end
    end

    // Output register and handshake: a finished frame loads when the slot is
    // free or being drained this cycle, otherwise it is dropped as an overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= fin_err;
            if (fin_ok && (!valid || ready)) begin
                data       <= core_word;
                parity_err <= (PARITY_EN != 0) ? perr_q : 1'b0;
                valid      <= 1'b1;
            end else if (xfer) begin
                valid      <= 1'b0;
            end
            if (fin_ok && valid && !ready) overrun <= 1'b1;
            else if (xfer)                 overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer (DATA_W=8, parity on).
module tb_serial_frame_deserializer;
    import sfd_pkg::*;

    localparam int DW   = 8;
    localparam int PE   = 1;
    localparam int FLEN = sfd_frame_len(DW, PE);

    logic          clk, rst, in, mode, ready;
    logic [DW-1:0] data;
    logic          valid, parity_err, frame_err, overrun, busy;

    int total = 0;
    int bad   = 0;

    // transfer log observed at the handshake
    logic [DW-1:0] got_d[$];
    logic          got_p[$];
    int            got_c[$];
    int            cyc    = 0;
    int            fe_cnt = 0;

    serial_frame_deserializer #(.DATA_W(DW), .PARITY_EN(PE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (in),
        .mode       (mode),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        #7;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst && valid && ready) begin
            got_d.push_back(data);
            got_p.push_back(parity_err);
            got_c.push_back(cyc);
        end
        if (rst && frame_err) fe_cnt++;
    end

    // Word the spec's assembly rule yields from a transmitted bit sequence
    // (seq[i] = i-th bit on the line)
    function automatic logic [DW-1:0] model_word(input logic [DW-1:0] seq, input logic m);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW; i++) w[m ? (DW - 1 - i) : i] = seq[i];
        return w;
    endfunction

    // Drives one full frame; returns #1 after the stop-bit edge with the line idle.
    // mode is flipped after the start bit to show it is latched.
    task automatic send_frame(input logic [DW-1:0] seq, input logic m,
                              input logic pbit, input logic sbit);
        in = 1'b1; mode = m;
        @(posedge clk); #1;
        mode = ~m;
        for (int i = 0; i < DW; i++) begin
            in = seq[i];
            @(posedge clk); #1;
        end
        if (PE != 0) begin
            in = pbit;
            @(posedge clk); #1;
        end
        in = sbit;
        @(posedge clk); #1;
        in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; in = 1'b0; mode = 1'b0; ready = 1'b0;
        #1;
        total++;
        if ({valid, busy, parity_err, frame_err, overrun, data} !== '0) begin
            bad++; $display("FAIL reset_async got %h want 0", {valid, busy, parity_err, frame_err, overrun, data});
        end
        #4 rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if ({valid, busy, parity_err, frame_err, overrun, data} !== '0) begin
                bad++; $display("FAIL reset_idle cyc%0d got %h want 0", c, {valid, busy, parity_err, frame_err, overrun, data});
            end
        end
    endtask

    task automatic test_basic;
        logic [DW-1:0] seqs[7];
        logic          ms[7];
        logic [DW-1:0] exp;
        seqs[0] = 8'hA5; ms[0] = 1'b0;
        seqs[1] = 8'hA5; ms[1] = 1'b1;
        seqs[2] = 8'h01; ms[2] = 1'b1;
        seqs[3] = 8'h01; ms[3] = 1'b0;
        for (int k = 4; k < 7; k++) begin
            seqs[k] = DW'($urandom);
            ms[k]   = 1'($urandom);
        end
        ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp = model_word(seqs[k], ms[k]);
            send_frame(seqs[k], ms[k], ^seqs[k], STOP_BIT);
            total++;
            if (valid !== 1'b0) begin
                bad++; $display("FAIL basic_early_valid k%0d got %b want 0", k, valid);
            end
            @(posedge clk); #1;
            total++;
            if (valid !== 1'b1 || data !== exp || parity_err !== 1'b0) begin
                bad++; $display("FAIL basic_word k%0d got v=%b d=%h p=%b want v=1 d=%h p=0", k, valid, data, parity_err, exp);
            end
            ready = 1'b1;
            @(posedge clk); #1;
            ready = 1'b0;
            total++;
            if (valid !== 1'b0) begin
                bad++; $display("FAIL basic_drop k%0d got %b want 0", k, valid);
            end
        end
    endtask

    task automatic test_errors;
        ready = 1'b0;
        send_frame(8'h03, 1'b0, 1'b1, STOP_BIT);
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b1 || data !== 8'h03 || parity_err !== 1'b1) begin
            bad++; $display("FAIL parity_err got v=%b d=%h p=%b want v=1 d=03 p=1", valid, data, parity_err);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        send_frame(8'h5C, 1'b0, ^8'h5C, 1'b1);
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL frame_err_early got %b want 0", frame_err);
        end
        @(posedge clk); #1;
        total++;
        if (frame_err !== 1'b1 || valid !== 1'b0) begin
            bad++; $display("FAIL frame_err_pulse got fe=%b v=%b want fe=1 v=0", frame_err, valid);
        end
        @(posedge clk); #1;
        total++;
        if (frame_err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL frame_err_end got fe=%b v=%b b=%b want 0 0 0", frame_err, valid, busy);
        end
    endtask

    task automatic test_overrun;
        got_d.delete(); got_p.delete(); got_c.delete();
        ready = 1'b0;
        send_frame(8'h11, 1'b0, ^8'h11, STOP_BIT);
        send_frame(8'h22, 1'b0, ^8'h22, STOP_BIT);
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b1 || data !== 8'h11 || overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_hold got v=%b d=%h o=%b want v=1 d=11 o=1", valid, data, overrun);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        total++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_clear got v=%b o=%b want 0 0", valid, overrun);
        end
        // drain and delivery on the same edge: no bubble
        send_frame(8'h33, 1'b0, ^8'h33, STOP_BIT);
        send_frame(8'h44, 1'b1, ^8'h44, STOP_BIT);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        total++;
        if (valid !== 1'b1 || data !== model_word(8'h44, 1'b1) || overrun !== 1'b0) begin
            bad++; $display("FAIL handoff got v=%b d=%h o=%b want v=1 d=%h o=0", valid, data, overrun, model_word(8'h44, 1'b1));
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        total++;
        if (got_d.size() != 3) begin
            bad++; $display("FAIL overrun_log_size got %0d want 3", got_d.size());
        end else begin
            total++;
            if (got_d[0] !== 8'h11 || got_d[1] !== 8'h33 || got_d[2] !== model_word(8'h44, 1'b1)) begin
                bad++; $display("FAIL overrun_log got %h %h %h want 11 33 %h", got_d[0], got_d[1], got_d[2], model_word(8'h44, 1'b1));
            end
        end
    endtask

    task automatic test_back_to_back;
        got_d.delete(); got_p.delete(); got_c.delete();
        ready = 1'b1;
        for (int w = 1; w <= 4; w++) send_frame(DW'(w), 1'b0, ^(DW'(w)), STOP_BIT);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (got_d.size() != 4) begin
            bad++; $display("FAIL b2b_count got %0d want 4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_d[i] !== DW'(i + 1)) begin
                    bad++; $display("FAIL b2b_word%0d got %h want %h", i, got_d[i], DW'(i + 1));
                end
                if (i > 0) begin
                    total++;
                    if (got_c[i] - got_c[i-1] != FLEN) begin
                        bad++; $display("FAIL b2b_gap%0d got %0d want %0d", i, got_c[i] - got_c[i-1], FLEN);
                    end
                end
            end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] exp_d[$];
        logic          exp_p[$];
        int            exp_fe;
        logic [DW-1:0] seq;
        logic          m, pb, sb;
        got_d.delete(); got_p.delete(); got_c.delete();
        fe_cnt = 0; exp_fe = 0;
        ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            seq = DW'($urandom);
            m   = 1'($urandom);
            pb  = ($urandom_range(0, 3) == 0) ? ~(^seq) : ^seq;
            sb  = ($urandom_range(0, 5) == 0) ? 1'b1 : STOP_BIT;
            if (sb == STOP_BIT) begin
                exp_d.push_back(model_word(seq, m));
                exp_p.push_back(pb != ^seq);
            end else begin
                exp_fe++;
            end
            send_frame(seq, m, pb, sb);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (got_d.size() != exp_d.size() || fe_cnt != exp_fe) begin
            bad++; $display("FAIL rand_counts got w=%0d fe=%0d want w=%0d fe=%0d", got_d.size(), fe_cnt, exp_d.size(), exp_fe);
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_p[i] !== exp_p[i]) begin
                    bad++; $display("FAIL rand_word%0d got d=%h p=%b want d=%h p=%b", i, got_d[i], got_p[i], exp_d[i], exp_p[i]);
                end
            end
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL rand_overrun got %b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid;
        ready = 1'b0;
        send_frame(8'h5A, 1'b0, ^8'h5A, STOP_BIT);
        @(posedge clk); #1;
        in = 1'b1; mode = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            in = 1'($urandom);
            @(posedge clk); #1;
        end
        total++;
        if (busy !== 1'b1 || valid !== 1'b1) begin
            bad++; $display("FAIL midreset_pre got b=%b v=%b want 1 1", busy, valid);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({valid, busy, parity_err, frame_err, overrun, data} !== '0) begin
            bad++; $display("FAIL midreset_clear got %h want 0", {valid, busy, parity_err, frame_err, overrun, data});
        end
        in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_nopartial got v=%b b=%b want 0 0", valid, busy);
        end
        send_frame(8'hC3, 1'b1, 1'b1, STOP_BIT);
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b1 || data !== model_word(8'hC3, 1'b1) || parity_err !== 1'b1) begin
            bad++; $display("FAIL midreset_after got v=%b d=%h p=%b want v=1 d=%h p=1", valid, data, parity_err, model_word(8'hC3, 1'b1));
        end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
